// File: rtl/escalonador_processos_if.sv
// -----------------------------------------------------------------------------
// escalonador_processos_if
// Signal bundle between the LabSO core (master) and the round-robin process
// scheduler (slave).
//   habilita          core -> sched : core executes this cycle
//   pc_atual          core -> sched : current PC, saved on a switch
//   troca_req         core -> sched : voluntary yield pulse
//   halt_processo     core -> sched : current process executed HALT
//   processo_atual    sched -> core : running process index
//   pc_restaurado     sched -> core : PC to load on a switch
//   carrega_pc        sched -> core : one-cycle load strobe for the PC register
//   troca_ativa       sched -> core : pipeline stall during a switch
//   todos_finalizados sched -> core : every process has halted
// With QUANTUM_PROG_EN defined, quantum_in / escreve_quantum are added so the
// core can program the time-slice length at run time.
// -----------------------------------------------------------------------------
interface escalonador_processos_if #(
    parameter int PROC_W = 1,
    parameter int PC_W   = 11
);
    logic              habilita;
    logic [PC_W-1:0]   pc_atual;
    logic              troca_req;
    logic              halt_processo;
    logic [PROC_W-1:0] processo_atual;
    logic [PC_W-1:0]   pc_restaurado;
    logic              carrega_pc;
    logic              troca_ativa;
    logic              todos_finalizados;
`ifdef QUANTUM_PROG_EN
    logic [7:0]        quantum_in;
    logic              escreve_quantum;
`endif

    modport master (
        output habilita, pc_atual, troca_req, halt_processo,
`ifdef QUANTUM_PROG_EN
        output quantum_in, escreve_quantum,
`endif
        input  processo_atual, pc_restaurado, carrega_pc, troca_ativa,
        input  todos_finalizados
    );

    modport slave (
        input  habilita, pc_atual, troca_req, halt_processo,
`ifdef QUANTUM_PROG_EN
        input  quantum_in, escreve_quantum,
`endif
        output processo_atual, pc_restaurado, carrega_pc, troca_ativa,
        output todos_finalizados
    );
endinterface

// File: rtl/escalonador_processos.sv
// -----------------------------------------------------------------------------
// escalonador_processos
// Round-robin process scheduler and context-switch controller for the
// multi-process LabSO core. Keeps one saved PC and an active flag per process
// slot, counts the time slice, and walks EXECUTA -> SALVA -> SELECIONA ->
// RESTAURA on a halt, a yield or a quantum expiry. OCIOSO is terminal once
// every process has halted (left only by reset).
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : escalonador_processos_if.slave (see interface header)
// Optional feature: define QUANTUM_PROG_EN to add a run-time programmable
// quantum (bus.quantum_in / bus.escreve_quantum); otherwise the quantum is the
// constant QUANTUM.
// -----------------------------------------------------------------------------
module escalonador_processos #(
    parameter int NUM_PROC  = 2,
    parameter int PROC_W    = 1,
    parameter int PC_W      = 11,
    parameter int TAM_BLOCO = 300,
    parameter int QUANTUM   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    escalonador_processos_if.slave bus
);
    localparam int CNT_W = ($clog2(QUANTUM + 1) > 8) ? $clog2(QUANTUM + 1) : 8;

    typedef enum logic [2:0] {
        EXECUTA,
        SALVA,
        SELECIONA,
        RESTAURA,
        OCIOSO
    } estado_t;

    estado_t           estado;
    logic [CNT_W-1:0]  contador;
    logic [CNT_W-1:0]  limite;
    logic [PC_W-1:0]   pc_salvo [NUM_PROC];
    logic [NUM_PROC-1:0] ativo;
    logic              halt_pend;
    logic [PROC_W-1:0] processo_atual_r;
    logic [PC_W-1:0]   pc_restaurado_r;
    logic              carrega_pc_r;
    logic              troca_ativa_r;
    logic              todos_r;
    logic [PROC_W:0]   sel;
    logic              evento;

    // Nearest active slot after 'atual', wrapping; k == NUM_PROC lands on
    // 'atual' itself so a lone survivor is reselected. MSB = slot found.
    function automatic logic [PROC_W:0] busca_prox(input logic [NUM_PROC-1:0] vivos,
                                                   input logic [PROC_W-1:0]   atual);
        logic [PROC_W:0] res;
        int idx;
        res = '0;
        for (int k = NUM_PROC; k >= 1; k--) begin
            idx = (int'(atual) + k) % NUM_PROC;
            if (vivos[idx]) res = {1'b1, PROC_W'(idx)};
        end
        return res;
    endfunction

`ifdef QUANTUM_PROG_EN
    logic [7:0] quantum_prog;   // last value written by the core
    logic [7:0] quantum_fatia;  // value in force for the current slice

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quantum_prog  <= 8'(QUANTUM);
            quantum_fatia <= 8'(QUANTUM);
        end else begin
            if (bus.escreve_quantum)
                quantum_prog <= (bus.quantum_in == 8'd0) ? 8'd1 : bus.quantum_in;
            // A new slice starts when RESTAURA hands control back.
            if (estado == RESTAURA)
                quantum_fatia <= quantum_prog;
        end
    end

    assign limite = CNT_W'(quantum_fatia) - CNT_W'(1);
`else
    assign limite = CNT_W'(QUANTUM - 1);
`endif

    assign evento = bus.halt_processo | bus.troca_req
                  | (bus.habilita && (contador == limite));
    assign sel    = busca_prox(ativo, processo_atual_r);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= EXECUTA;
            contador         <= '0;
            ativo            <= '1;
            halt_pend        <= 1'b0;
            processo_atual_r <= '0;
            pc_restaurado_r  <= '0;
            carrega_pc_r     <= 1'b0;
            troca_ativa_r    <= 1'b0;
            todos_r          <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++)
                pc_salvo[i] <= PC_W'(i * TAM_BLOCO);
        end else begin
            case (estado)
                EXECUTA: begin
                    if (bus.habilita)
                        contador <= contador + CNT_W'(1);
                    if (evento) begin
                        estado        <= SALVA;
                        troca_ativa_r <= 1'b1;
                        // Halt wins over a simultaneous yield or expiry.
                        halt_pend     <= bus.halt_processo;
                    end
                end
                SALVA: begin
                    pc_salvo[processo_atual_r] <= bus.pc_atual;
                    if (halt_pend)
                        ativo[processo_atual_r] <= 1'b0;
                    estado <= SELECIONA;
                end
                SELECIONA: begin
                    if (!sel[PROC_W]) begin
                        estado  <= OCIOSO;
                        todos_r <= 1'b1;
                    end else begin
                        // Outputs are registered, so the new index and PC are
                        // presented together with the load strobe in RESTAURA.
                        estado           <= RESTAURA;
                        processo_atual_r <= sel[PROC_W-1:0];
                        pc_restaurado_r  <= pc_salvo[sel[PROC_W-1:0]];
                        carrega_pc_r     <= 1'b1;
                    end
                end
                RESTAURA: begin
                    carrega_pc_r  <= 1'b0;
                    troca_ativa_r <= 1'b0;
                    contador      <= '0;
                    estado        <= EXECUTA;
                end
                OCIOSO: begin
                    estado <= OCIOSO;
                end
                default: estado <= EXECUTA;
            endcase
        end
    end

    assign bus.processo_atual    = processo_atual_r;
    assign bus.pc_restaurado     = pc_restaurado_r;
    assign bus.carrega_pc        = carrega_pc_r;
    assign bus.troca_ativa       = troca_ativa_r;
    assign bus.todos_finalizados = todos_r;
endmodule

// File: tb/tb_escalonador_processos.sv
// -----------------------------------------------------------------------------
// tb_escalonador_processos
// Directed bench for escalonador_processos (default parameters). Inputs are
// driven 1 time unit after the rising edge, outputs sampled at the same point
// (i.e. reflecting the registers updated by that edge).
// -----------------------------------------------------------------------------
module tb_escalonador_processos;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n;

    escalonador_processos_if #(.PROC_W(1), .PC_W(11)) bus ();

    escalonador_processos dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs === esp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    endtask

    task automatic passo(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Number of edges until carrega_pc is seen, -1 if it never shows up.
    task automatic espera_carga(input int limite_ciclos, output int nc);
        nc = -1;
        for (int k = 1; k <= limite_ciclos; k++) begin
            @(posedge clock);
            #1;
            if (bus.carrega_pc) begin
                nc = k;
                break;
            end
        end
    endtask

    task automatic aplica_reset();
        bus.habilita      = 1'b0;
        bus.troca_req     = 1'b0;
        bus.halt_processo = 1'b0;
        reset = 1'b1;
        passo(2);
        verifica("reset processo_atual", 32'(bus.processo_atual), 0);
        verifica("reset pc_restaurado", 32'(bus.pc_restaurado), 0);
        verifica("reset carrega_pc", 32'(bus.carrega_pc), 0);
        verifica("reset troca_ativa", 32'(bus.troca_ativa), 0);
        verifica("reset todos_finalizados", 32'(bus.todos_finalizados), 0);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.habilita      = 1'b0;
        bus.pc_atual      = '0;
        bus.troca_req     = 1'b0;
        bus.halt_processo = 1'b0;
`ifdef QUANTUM_PROG_EN
        bus.quantum_in      = 8'd0;
        bus.escreve_quantum = 1'b0;
`endif

        // Quantum expiry: 16 enabled cycles, then SALVA/SELECIONA/RESTAURA.
        aplica_reset();
        bus.habilita = 1'b1;
        bus.pc_atual = 11'd15;
        passo(15);
        verifica("q1 troca_ativa before expiry", 32'(bus.troca_ativa), 0);
        passo(1);
        verifica("q1 troca_ativa after expiry", 32'(bus.troca_ativa), 1);
        espera_carga(10, n);
        verifica("q1 carga latency", 32'(n), 2);
        verifica("q1 processo_atual", 32'(bus.processo_atual), 1);
        verifica("q1 pc_restaurado", 32'(bus.pc_restaurado), 300);
        verifica("q1 troca_ativa in RESTAURA", 32'(bus.troca_ativa), 1);
        bus.pc_atual = 11'd310;
        passo(1);
        verifica("q1 carga pulse width", 32'(bus.carrega_pc), 0);
        verifica("q1 troca_ativa dropped", 32'(bus.troca_ativa), 0);
        // 4 enabled cycles, 5 stalled, then 12 more enabled to expiry.
        passo(4);
        bus.habilita = 1'b0;
        passo(5);
        bus.habilita = 1'b1;
        espera_carga(40, n);
        verifica("q2 latency with habilita gap", 32'(n), 14);
        verifica("q2 processo_atual", 32'(bus.processo_atual), 0);
        verifica("q2 pc_restaurado", 32'(bus.pc_restaurado), 15);

        // Yield at cycle 5 with pc_atual=7.
        aplica_reset();
        bus.habilita = 1'b1;
        bus.pc_atual = 11'd7;
        passo(4);
        bus.troca_req = 1'b1;
        passo(1);
        bus.troca_req = 1'b0;
        espera_carga(10, n);
        verifica("yield carga latency", 32'(n), 2);
        verifica("yield processo_atual", 32'(bus.processo_atual), 1);
        verifica("yield pc_restaurado", 32'(bus.pc_restaurado), 300);
        // A yield while in RESTAURA must be ignored.
        bus.troca_req = 1'b1;
        bus.pc_atual  = 11'd400;
        passo(1);
        bus.troca_req = 1'b0;
        verifica("yield ignored in RESTAURA a", 32'(bus.troca_ativa), 0);
        passo(1);
        verifica("yield ignored in RESTAURA b", 32'(bus.troca_ativa), 0);
        bus.troca_req = 1'b1;
        passo(1);
        bus.troca_req = 1'b0;
        espera_carga(10, n);
        verifica("yield2 carga latency", 32'(n), 2);
        verifica("yield2 processo_atual", 32'(bus.processo_atual), 0);
        verifica("yield2 pc_restaurado", 32'(bus.pc_restaurado), 7);

        // Halt process 0; process 1 keeps being reselected.
        aplica_reset();
        bus.habilita = 1'b1;
        bus.pc_atual = 11'd20;
        passo(2);
        bus.halt_processo = 1'b1;
        passo(1);
        bus.halt_processo = 1'b0;
        espera_carga(10, n);
        verifica("halt0 carga latency", 32'(n), 2);
        verifica("halt0 processo_atual", 32'(bus.processo_atual), 1);
        verifica("halt0 pc_restaurado", 32'(bus.pc_restaurado), 300);
        bus.pc_atual = 11'd333;
        espera_carga(40, n);
        verifica("reselect1 latency", 32'(n), 19);
        verifica("reselect1 processo_atual", 32'(bus.processo_atual), 1);
        verifica("reselect1 pc_restaurado", 32'(bus.pc_restaurado), 333);
        bus.pc_atual = 11'd350;
        espera_carga(40, n);
        verifica("reselect2 processo_atual", 32'(bus.processo_atual), 1);
        verifica("reselect2 pc_restaurado", 32'(bus.pc_restaurado), 350);

        // Halt the last process: OCIOSO, no load strobe.
        passo(3);
        bus.halt_processo = 1'b1;
        passo(1);
        bus.halt_processo = 1'b0;
        verifica("halt1 SALVA troca_ativa", 32'(bus.troca_ativa), 1);
        verifica("halt1 SALVA todos", 32'(bus.todos_finalizados), 0);
        passo(1);
        verifica("halt1 SELECIONA todos", 32'(bus.todos_finalizados), 0);
        passo(1);
        verifica("ocioso todos_finalizados", 32'(bus.todos_finalizados), 1);
        verifica("ocioso troca_ativa", 32'(bus.troca_ativa), 1);
        verifica("ocioso carrega_pc", 32'(bus.carrega_pc), 0);
        bus.troca_req = 1'b1;
        espera_carga(30, n);
        bus.troca_req = 1'b0;
        verifica("ocioso never loads", 32'(n), -1);
        verifica("ocioso held", 32'(bus.todos_finalizados), 1);

        // Halt + yield + quantum expiry in the same cycle: one switch only.
        aplica_reset();
        bus.habilita = 1'b1;
        bus.pc_atual = 11'd44;
        passo(15);
        bus.halt_processo = 1'b1;
        bus.troca_req     = 1'b1;
        passo(1);
        bus.halt_processo = 1'b0;
        bus.troca_req     = 1'b0;
        espera_carga(10, n);
        verifica("combo carga latency", 32'(n), 2);
        verifica("combo processo_atual", 32'(bus.processo_atual), 1);
        verifica("combo pc_restaurado", 32'(bus.pc_restaurado), 300);
        bus.pc_atual = 11'd500;
        espera_carga(40, n);
        verifica("combo single switch", 32'(n), 19);
        verifica("combo halted slot skipped", 32'(bus.processo_atual), 1);
        verifica("combo reselect pc", 32'(bus.pc_restaurado), 500);

        // Reset asserted while in SELECIONA.
        aplica_reset();
        bus.habilita = 1'b1;
        bus.pc_atual = 11'd55;
        passo(2);
        bus.troca_req = 1'b1;
        passo(1);
        bus.troca_req = 1'b0;
        passo(1);
        verifica("midswitch troca_ativa", 32'(bus.troca_ativa), 1);
        reset = 1'b1;
        #1;
        verifica("midswitch reset troca_ativa", 32'(bus.troca_ativa), 0);
        verifica("midswitch reset processo_atual", 32'(bus.processo_atual), 0);
        verifica("midswitch reset pc_restaurado", 32'(bus.pc_restaurado), 0);
        passo(2);
        verifica("midswitch no carga", 32'(bus.carrega_pc), 0);
        reset = 1'b0;
        bus.pc_atual = 11'd77;
        espera_carga(40, n);
        verifica("post-reset first slice", 32'(n), 18);
        verifica("post-reset processo_atual", 32'(bus.processo_atual), 1);
        verifica("post-reset pc_restaurado", 32'(bus.pc_restaurado), 300);

`ifdef QUANTUM_PROG_EN
        // Program 0 (stored as 1), then 4; each applies from the next slice.
        aplica_reset();
        bus.habilita        = 1'b1;
        bus.quantum_in      = 8'd0;
        bus.escreve_quantum = 1'b1;
        espera_carga(40, n);
        verifica("qprog slice default", 32'(n), 18);
        bus.quantum_in = 8'd4;
        espera_carga(20, n);
        verifica("qprog slice 1", 32'(n), 4);
        bus.escreve_quantum = 1'b0;
        espera_carga(20, n);
        verifica("qprog slice 4", 32'(n), 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
